// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared encodings and lane helpers for the sized data memory
//
// Purpose:
//   Size encodings, the clear/idle state enum, and small pure functions that
//   turn (Size, byte offset) into alignment status, byte-lane write enables
//   and lane-replicated store data. Shared by the data memory and fetch path.
// Contents:
//   SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD  2-bit access size codes
//   mem_state_t                       ST_CLEAR (post-reset sweep), ST_IDLE
//   is_misaligned()                   1 when the access cannot be performed
//   lane_enables()                    little-endian byte-lane write mask
//   store_lanes()                     store data replicated across lanes

package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } mem_state_t;

  // Halves need an even address, words a multiple of four. The reserved
  // size code is reported as misaligned so it is rejected the same way.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = |addr_lo;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

  // Lane 0 is bits [7:0]; assumes the access has already passed alignment.
  function automatic logic [3:0] lane_enables(input logic [1:0] size,
                                              input logic [1:0] addr_lo);
    logic [3:0] en;
    case (size)
      SZ_BYTE: en = 4'b0001 << addr_lo;
      SZ_HALF: en = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: en = 4'b1111;
      default: en = 4'b0000;
    endcase
    return en;
  endfunction

  // Right-justified store data copied into every lane it could land in, so
  // the lane enables alone decide which bytes are written.
  function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                              input logic [31:0] data);
    logic [31:0] rep;
    case (size)
      SZ_BYTE: rep = {4{data[7:0]}};
      SZ_HALF: rep = {2{data[15:0]}};
      default: rep = data;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - load lane select with sign/zero extension
//
// Purpose:
//   Purely combinational. Picks the addressed byte or half out of a 32-bit
//   word and extends it to 32 bits. Word (and reserved) sizes pass through.
// Ports:
//   Word        in   32  raw word read from the array
//   ByteOffset  in   2   Address[1:0] of the load
//   Size        in   2   access size code
//   Unsigned    in   1   1 zero-extend, 0 sign-extend
//   Data        out  32  extended load result

module mem_load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] Word,
  input  logic [1:0]  ByteOffset,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic [31:0] Data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = Word[{ByteOffset, 3'b000} +: 8];
    half_sel = ByteOffset[1] ? Word[31:16] : Word[15:0];
    case (Size)
      SZ_BYTE: Data = Unsigned ? {24'h000000, byte_sel}
                               : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: Data = Unsigned ? {16'h0000, half_sel}
                               : {{16{half_sel[15]}}, half_sel};
      default: Data = Word;
    endcase
  end

endmodule

// File: rtl/data_memory_sized.sv
// rtl/data_memory_sized.sv - byte-addressed sized data memory with clear sweep
//
// Purpose:
//   Data memory for the single-cycle MIPS datapath. Byte/half/word loads and
//   stores with byte-lane enables, a registered read port (one result per
//   cycle), misalignment rejection, and an optional post-reset zero sweep.
// Ports:
//   Clock        in   1             all state on rising edge
//   Reset        in   1             asynchronous, active-high
//   Address      in   DEPTH_LOG2+2  byte address
//   WriteData    in   32            right-justified store data
//   MemoryRead   in   1             load request
//   MemoryWrite  in   1             store request
//   Size         in   2             00 byte, 01 half, 10 word, 11 reserved
//   Unsigned     in   1             loads: 1 zero-extend, 0 sign-extend
//   ReadData     out  32            registered, extended load result
//   ReadValid    out  1             pulse: ReadData is last cycle's load
//   Misaligned   out  1             pulse: last cycle's request was rejected
//   Ready        out  1             requests are accepted

module data_memory_sized
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_LOG2     = 6,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DEPTH_LOG2+1:0] Address,
  input  logic [31:0]           WriteData,
  input  logic                  MemoryRead,
  input  logic                  MemoryWrite,
  input  logic [1:0]            Size,
  input  logic                  Unsigned,
  output logic [31:0]           ReadData,
  output logic                  ReadValid,
  output logic                  Misaligned,
  output logic                  Ready
);

  localparam int                    DEPTH       = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] LAST_WORD   = DEPTH_LOG2'(DEPTH - 1);
  localparam mem_state_t            RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  mem_state_t state;
  mem_state_t next_state;
  logic       clear_active;

  logic [DEPTH_LOG2-1:0] clear_cnt;

  logic [31:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] word_idx;
  logic [1:0]            byte_off;
  logic                  accept;
  logic                  req_any;
  logic                  req_misaligned;
  logic                  load_ok;
  logic                  store_ok;

  logic [3:0]            wr_lanes;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [31:0]           wr_word;

  logic [31:0] rd_word;
  logic [31:0] load_data;

  assign word_idx = Address[DEPTH_LOG2+1:2];
  assign byte_off = Address[1:0];

  // ---------------------------------------------------------------------------
  // Clear sequencer: state register, next-state logic, state outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= RESET_STATE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_CLEAR: if (clear_cnt == LAST_WORD) next_state = ST_IDLE;
      ST_IDLE:  next_state = ST_IDLE;
      default:  next_state = RESET_STATE;
    endcase
  end

  always_comb begin
    Ready        = 1'b0;
    clear_active = 1'b0;
    case (state)
      ST_CLEAR: clear_active = 1'b1;
      ST_IDLE:  Ready        = 1'b1;
      default:  ;
    endcase
  end

  // Wraps back to zero on the last sweep write, so it is already at the
  // right start value if the design is ever re-swept without a reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      clear_cnt <= '0;
    end else if (clear_active) begin
      clear_cnt <= clear_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Request qualification
  // ---------------------------------------------------------------------------
  // Reset gates acceptance too: without the sweep the FSM sits in IDLE during
  // reset and would otherwise let a store through while Reset is held.
  assign accept         = Ready & ~Reset;
  assign req_any        = MemoryRead | MemoryWrite;
  assign req_misaligned = is_misaligned(Size, byte_off);
  assign load_ok        = accept & MemoryRead  & ~req_misaligned;
  assign store_ok       = accept & MemoryWrite & ~req_misaligned;

  // ---------------------------------------------------------------------------
  // Single write port shared by the sweep and by stores
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_lanes = 4'b0000;
    wr_idx   = word_idx;
    wr_word  = store_lanes(Size, WriteData);
    if (clear_active) begin
      wr_lanes = 4'b1111;
      wr_idx   = clear_cnt;
      wr_word  = '0;
    end else if (store_ok) begin
      wr_lanes = lane_enables(Size, byte_off);
    end
  end

  // The array has no reset; its contents are defined by the sweep.
  always_ff @(posedge Clock) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_lanes[b]) begin
        mem[wr_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: asynchronous array read captured into the output register on
  // the same edge the store lands, which gives read-first behaviour.
  // ---------------------------------------------------------------------------
  assign rd_word = mem[word_idx];

  mem_load_align u_load_align (
    .Word       (rd_word),
    .ByteOffset (byte_off),
    .Size       (Size),
    .Unsigned   (Unsigned),
    .Data       (load_data)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ReadData   <= '0;
      ReadValid  <= 1'b0;
      Misaligned <= 1'b0;
    end else begin
      ReadValid  <= load_ok;
      Misaligned <= accept & req_any & req_misaligned;
      if (load_ok) begin
        ReadData <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_sized.sv
// tb/tb_data_memory_sized.sv - self-checking bench for data_memory_sized

module tb_data_memory_sized;

  localparam int DL2    = 6;
  localparam int DEPTH  = 1 << DL2;
  localparam int NBYTES = DEPTH * 4;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [7:0]  Address;
  logic [31:0] WriteData;
  logic        MemoryRead;
  logic        MemoryWrite;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [31:0] ReadData;
  logic        ReadValid;
  logic        Misaligned;
  logic        Ready;

  data_memory_sized #(.DEPTH_LOG2(DL2), .CLEAR_ON_RESET(1'b1)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Address     (Address),
    .WriteData   (WriteData),
    .MemoryRead  (MemoryRead),
    .MemoryWrite (MemoryWrite),
    .Size        (Size),
    .Unsigned    (Unsigned),
    .ReadData    (ReadData),
    .ReadValid   (ReadValid),
    .Misaligned  (Misaligned),
    .Ready       (Ready)
  );

  always #5 Clock = ~Clock;

  int vectors    = 0;
  int miscompares = 0;
  bit checking   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: flat byte array, little-endian, plus a ready countdown.
  // After any reset the memory is all zero by the time Ready rises, so the
  // model simply zeroes everything on reset.
  // ---------------------------------------------------------------------------
  logic [7:0]  mbytes [NBYTES];
  int          countdown;
  logic [31:0] exp_rdata;
  logic        exp_valid;
  logic        exp_mis;
  logic        exp_ready;
  int          m_n;
  int          m_a;
  logic [31:0] m_v;

  function automatic bit model_misaligned(input logic [1:0] sz, input logic [7:0] a);
    if (sz == 2'b11) return 1'b1;
    return (int'(a) % (1 << sz)) != 0;
  endfunction

  initial forever begin
    @(posedge Clock or posedge Reset);
    if (Reset) begin
      for (int i = 0; i < NBYTES; i++) mbytes[i] = 8'h00;
      countdown = DEPTH;
      exp_rdata = 32'h0;
      exp_valid = 1'b0;
      exp_mis   = 1'b0;
      exp_ready = 1'b0;
    end else begin
      exp_valid = 1'b0;
      exp_mis   = 1'b0;
      if (countdown > 0) begin
        countdown--;
      end else if (MemoryRead || MemoryWrite) begin
        if (model_misaligned(Size, Address)) begin
          exp_mis = 1'b1;
        end else begin
          m_n = 1 << Size;
          m_a = int'(Address);
          if (MemoryRead) begin
            m_v = 32'h0;
            for (int i = 0; i < m_n; i++) m_v = m_v | (32'(mbytes[m_a + i]) << (8 * i));
            if (!Unsigned && m_n < 4 && m_v[8*m_n-1]) m_v = m_v | (32'hFFFFFFFF << (8 * m_n));
            exp_rdata = m_v;
            exp_valid = 1'b1;
          end
          if (MemoryWrite) begin
            for (int i = 0; i < m_n; i++) mbytes[m_a + i] = WriteData[8*i +: 8];
          end
        end
      end
      exp_ready = (countdown == 0);
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial forever begin
    @(negedge Clock);
    if (checking) begin
      chk("ReadData",   ReadData,          exp_rdata);
      chk("ReadValid",  32'(ReadValid),    32'(exp_valid));
      chk("Misaligned", 32'(Misaligned),   32'(exp_mis));
      chk("Ready",      32'(Ready),        32'(exp_ready));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at a negedge, return at the next negedge)
  // ---------------------------------------------------------------------------
  task automatic op(input logic rd, input logic wr, input logic [1:0] sz,
                    input logic uns, input logic [7:0] a, input logic [31:0] d);
    MemoryRead  = rd;
    MemoryWrite = wr;
    Size        = sz;
    Unsigned    = uns;
    Address     = a;
    WriteData   = d;
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic set_idle();
    MemoryRead  = 1'b0;
    MemoryWrite = 1'b0;
  endtask

  task automatic rand_inputs();
    logic [7:0] a;
    logic [1:0] sz;
    int r;
    a  = ($urandom_range(1) == 0) ? 8'($urandom_range(31)) : 8'($urandom);
    sz = 2'($urandom);
    if ($urandom_range(3) != 0) begin
      if (sz == 2'b01) a[0] = 1'b0;
      if (sz == 2'b10) a[1:0] = 2'b00;
    end
    r = $urandom_range(99);
    MemoryRead  = (r < 45) || (r >= 90);
    MemoryWrite = (r >= 45 && r < 80) || (r >= 90);
    Size        = sz;
    Address     = a;
    Unsigned    = 1'($urandom);
    WriteData   = $urandom;
  endtask

  task automatic count_sweep(input string name, input bit randomize_reqs);
    int cycles;
    cycles = 0;
    while (!Ready && cycles < 200) begin
      if (randomize_reqs) rand_inputs();
      @(negedge Clock);
      cycles++;
    end
    set_idle();
    chk(name, 32'(cycles), 32'd64);
  endtask

  initial begin
    Reset       = 1'b0;
    Address     = '0;
    WriteData   = '0;
    MemoryRead  = 1'b0;
    MemoryWrite = 1'b0;
    Size        = 2'b10;
    Unsigned    = 1'b0;

    #2 Reset = 1'b1;
    #1 checking = 1'b1;
    repeat (3) @(negedge Clock);
    chk("rst_ReadData",   ReadData,        32'h0);
    chk("rst_ReadValid",  32'(ReadValid),  32'h0);
    chk("rst_Misaligned", 32'(Misaligned), 32'h0);
    chk("rst_Ready",      32'(Ready),      32'h0);

    #2 Reset = 1'b0;
    count_sweep("sweep_len", 1'b0);

    op(1, 0, 2'b10, 0, 8'h24, 0);
    chk("lw_cleared", ReadData, 32'h0);
    chk("lw_cleared_valid", 32'(ReadValid), 32'h1);

    op(0, 1, 2'b10, 0, 8'h10, 32'hDEADBEEF);
    op(1, 0, 2'b00, 0, 8'h13, 0);
    chk("lb_13", ReadData, 32'hFFFFFFDE);
    op(1, 0, 2'b00, 1, 8'h13, 0);
    chk("lbu_13", ReadData, 32'h000000DE);
    op(1, 0, 2'b01, 0, 8'h10, 0);
    chk("lh_10", ReadData, 32'hFFFFBEEF);

    op(0, 1, 2'b00, 0, 8'h11, 32'h0000005A);
    op(1, 0, 2'b10, 0, 8'h10, 0);
    chk("sb_11", ReadData, 32'hDEAD5AEF);
    op(0, 1, 2'b01, 0, 8'h12, 32'h00001234);
    op(1, 0, 2'b10, 0, 8'h10, 0);
    chk("sh_12", ReadData, 32'h12345AEF);

    op(0, 1, 2'b10, 0, 8'h04, 32'hCAFEF00D);
    op(1, 0, 2'b10, 0, 8'h06, 0);
    chk("mis_lw06", 32'(Misaligned), 32'h1);
    chk("mis_lw06_valid", 32'(ReadValid), 32'h0);
    op(0, 1, 2'b01, 0, 8'h05, 32'h0000FFFF);
    chk("mis_sh05", 32'(Misaligned), 32'h1);
    op(1, 1, 2'b11, 0, 8'h04, 32'h77777777);
    chk("mis_rsvd", 32'(Misaligned), 32'h1);
    chk("mis_rsvd_valid", 32'(ReadValid), 32'h0);
    op(1, 0, 2'b10, 0, 8'h04, 0);
    chk("mis_untouched", ReadData, 32'hCAFEF00D);

    op(1, 1, 2'b10, 0, 8'h20, 32'h11111111);
    chk("rw_read_first", ReadData, 32'h0);
    op(1, 0, 2'b10, 0, 8'h20, 0);
    chk("rw_after", ReadData, 32'h11111111);

    repeat (3000) begin
      rand_inputs();
      @(negedge Clock);
    end
    set_idle();

    // Reset in the middle of an access.
    op(0, 1, 2'b10, 0, 8'h00, 32'hA5A5A5A5);
    op(1, 0, 2'b10, 0, 8'h00, 0);
    chk("pre_rst_load", ReadData, 32'hA5A5A5A5);
    MemoryRead = 1'b1;
    #2 Reset = 1'b1;
    #1;
    chk("acc_rst_ReadData",  ReadData,        32'h0);
    chk("acc_rst_ReadValid", 32'(ReadValid),  32'h0);
    chk("acc_rst_Ready",     32'(Ready),      32'h0);
    set_idle();
    @(negedge Clock);
    #2 Reset = 1'b0;

    // Interrupt the sweep at cycle 30, with requests hammering throughout.
    repeat (30) begin
      rand_inputs();
      @(negedge Clock);
    end
    #2 Reset = 1'b1;
    #1;
    chk("sweep_rst_ReadData",   ReadData,        32'h0);
    chk("sweep_rst_Misaligned", 32'(Misaligned), 32'h0);
    chk("sweep_rst_Ready",      32'(Ready),      32'h0);
    @(negedge Clock);
    #2 Reset = 1'b0;
    count_sweep("resweep_len", 1'b1);

    op(1, 0, 2'b10, 0, 8'h00, 0);
    chk("resweep_lw0", ReadData, 32'h0);
    op(1, 0, 2'b10, 0, 8'h20, 0);
    chk("resweep_lw20", ReadData, 32'h0);
    set_idle();
    repeat (2) @(negedge Clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
